// File: rtl/frame_pkg.sv
// Shared definitions for the command-frame link: field widths, FSM encodings and frame packing.
// The frame decoder on the far end of the link uses the same field widths.
package frame_pkg;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 4;
    localparam int FRAME_W = ADDR_W + DATA_W;

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_HOLD = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_BUSY = 2'd2
    } tx_state_t;

    function automatic logic [FRAME_W-1:0] pack_frame(input logic [ADDR_W-1:0] address,
                                                      input logic [DATA_W-1:0] data);
        return {address, data};
    endfunction

endpackage

// File: rtl/frame_encoder_if.sv
// Producer/transmitter-facing signal bundle of the frame encoder.
// The slave side is the encoder; the master side is the producer plus the byte transmitter.
interface frame_encoder_if #(
    parameter int DEPTH = 4
);
    import frame_pkg::*;

    logic [ADDR_W-1:0]       address;
    logic [DATA_W-1:0]       data;
    logic                    valid;
    logic                    ack;
    logic [FRAME_W-1:0]      frame;
    logic                    frame_valid;
    logic                    tx_busy;
    logic                    full;
    logic [$clog2(DEPTH):0]  count;

    modport master (
        output address, data, valid, tx_busy,
        input  ack, frame, frame_valid, full, count
    );

    modport slave (
        input  address, data, valid, tx_busy,
        output ack, frame, frame_valid, full, count
    );

endinterface

// File: rtl/frame_fifo.sv
// Synchronous frame buffer with registered full/empty/count.
// DEPTH must be a power of two (ring pointers wrap naturally) or exactly 1 (single holding register).
module frame_fifo
    import frame_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [FRAME_W-1:0] din,
    output logic [FRAME_W-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] count_next;

    // A pop in the same cycle lets a push land even when full; the slot is reused in place.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    generate
        if (DEPTH == 1) begin : g_single
            logic [FRAME_W-1:0] hold;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold <= '0;
                end else if (do_push) begin
                    hold <= din;
                end
            end

            assign dout = hold;
        end else begin : g_ring
            localparam int PTR_W = $clog2(DEPTH);

            logic [FRAME_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0]   wr_ptr;
            logic [PTR_W-1:0]   rd_ptr;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (do_push) wr_ptr <= wr_ptr + 1'b1;
                    if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (do_push) mem[wr_ptr] <= din;
            end

            assign dout = mem[rd_ptr];
        end
    endgenerate

endmodule

// File: rtl/frame_encoder.sv
// Packs {address,data} into command frames, buffers them and offers them to the byte transmitter.
// Build with FRAME_ENC_FIFO_EN for a DEPTH-entry buffer; otherwise a single holding register is used.
//
// state   | meaning
// IN_IDLE | waiting for valid with buffer space
// IN_HOLD | word taken, waiting for producer to drop valid
// TX_IDLE | waiting for a buffered word and an idle transmitter
// TX_SEND | frame offered, waiting for transmitter to go busy
// TX_BUSY | transmitter shifting the frame out
module frame_encoder
    import frame_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    frame_encoder_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef FRAME_ENC_FIFO_EN
    localparam int FIFO_DEPTH = DEPTH;
`else
    localparam int FIFO_DEPTH = 1;
`endif

    in_state_t          in_state;
    tx_state_t          tx_state;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [FRAME_W-1:0] head;

    assign push = (in_state == IN_IDLE) && bus.valid && !fifo_full;
    assign pop  = (tx_state == TX_IDLE) && !fifo_empty && !bus.tx_busy;

    frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pack_frame(bus.address, bus.data)),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.full  = fifo_full;
    assign bus.count = fifo_count;

    // One word per valid assertion: IN_HOLD blocks re-acceptance until valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state <= IN_IDLE;
            bus.ack  <= 1'b0;
        end else begin
            case (in_state)
                IN_IDLE: begin
                    bus.ack <= push;
                    if (push) in_state <= IN_HOLD;
                end
                IN_HOLD: begin
                    bus.ack <= 1'b0;
                    if (!bus.valid) in_state <= IN_IDLE;
                end
                default: begin
                    bus.ack  <= 1'b0;
                    in_state <= IN_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state        <= TX_IDLE;
            bus.frame       <= '0;
            bus.frame_valid <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (pop) begin
                        bus.frame       <= head;
                        bus.frame_valid <= 1'b1;
                        tx_state        <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (bus.tx_busy) begin
                        bus.frame_valid <= 1'b0;
                        tx_state        <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (!bus.tx_busy) tx_state <= TX_IDLE;
                end
                default: begin
                    bus.frame_valid <= 1'b0;
                    tx_state        <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_encoder.sv
// Self-checking bench for frame_encoder: directed handshake/boundary steps plus random traffic,
// scored against a queue of accepted words and the transmitter handshake rules.
module tb_frame_encoder;
    import frame_pkg::*;

`ifdef FRAME_ENC_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic force_busy;
    logic auto_busy;

    frame_encoder_if #(.DEPTH(4)) bus ();

    frame_encoder #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.tx_busy = force_busy | auto_busy;

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cur_word;
    logic [7:0] last_frame;
    bit         acked;
    bit         fv_q;
    bit         auto_tx;
    int         low_cnt;
    int         busy_left;
    int         n_acks;
    int         n_frames;
    int         peak;
    int         n0;
    int         f0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample at the falling edge, score, then advance the transmitter model.
    task automatic tick();
        logic       busy_at_edge;
        logic [7:0] w;
        @(negedge clk);
        busy_at_edge = bus.tx_busy;
        if (bus.ack === 1'b1) begin
            check("one_ack_per_valid", 32'(acked), 0);
            acked = 1'b1;
            n_acks++;
            exp_q.push_back(cur_word);
        end
        if (fv_q) begin
            if (busy_at_edge) begin
                check("fv_drop_on_busy", 32'(bus.frame_valid), 0);
            end else begin
                check("fv_held", 32'(bus.frame_valid), 1);
                check("frame_stable", 32'(bus.frame), 32'(last_frame));
            end
        end else if (bus.frame_valid === 1'b1) begin
            check("frame_gap", 32'(low_cnt >= 2), 1);
            w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check("frame_order", 32'(bus.frame), 32'(w));
            last_frame = bus.frame;
            n_frames++;
        end
        low_cnt = bus.frame_valid ? 0 : low_cnt + 1;
        fv_q    = bus.frame_valid;
        check("count", 32'(bus.count), 32'(exp_q.size()));
        check("full", 32'(bus.full), 32'(exp_q.size() == CAP));
        if (int'(bus.count) > peak) peak = int'(bus.count);
        if (auto_tx) begin
            if (auto_busy) begin
                if (busy_left == 0) auto_busy = 1'b0;
                else busy_left--;
            end else if (bus.frame_valid && $urandom_range(0, 1) == 0) begin
                auto_busy = 1'b1;
                busy_left = $urandom_range(1, 4);
            end
        end else begin
            auto_busy = 1'b0;
        end
    endtask

    task automatic raise(input logic [3:0] a, input logic [3:0] d);
        bus.address = a;
        bus.data    = d;
        cur_word    = {a, d};
        acked       = 1'b0;
        bus.valid   = 1'b1;
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 100 && !acked; i++) tick();
        check("ack_timeout", 32'(acked), 1);
    endtask

    task automatic send_word(input logic [3:0] a, input logic [3:0] d, input int hold);
        raise(a, d);
        wait_ack();
        repeat (hold) tick();
        bus.valid = 1'b0;
        tick();
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            tick();
            done = (exp_q.size() == 0) && !bus.frame_valid && !bus.tx_busy;
        end
        check("drain_timeout", 32'(done), 1);
        auto_tx = 1'b0;
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        force_busy  = 1'b0;
        auto_busy   = 1'b0;
        auto_tx     = 1'b0;
        bus.valid   = 1'b0;
        bus.address = '0;
        bus.data    = '0;
        cur_word    = '0;
        last_frame  = '0;
        acked       = 1'b1;
        fv_q        = 1'b0;
        low_cnt     = 100;
        busy_left   = 0;
        n_acks      = 0;
        n_frames    = 0;
        peak        = 0;

        repeat (3) @(negedge clk);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_frame", 32'(bus.frame), 0);
        check("rst_frame_valid", 32'(bus.frame_valid), 0);
        check("rst_full", 32'(bus.full), 0);
        check("rst_count", 32'(bus.count), 0);
        rst = 1'b0;
        tick();
        tick();

        // Single word with an idle transmitter
        raise(4'h3, 4'hA);
        tick();
        check("single_ack", 32'(bus.ack), 1);
        check("single_count", 32'(bus.count), 1);
        check("single_fv_early", 32'(bus.frame_valid), 0);
        bus.valid = 1'b0;
        tick();
        check("single_fv", 32'(bus.frame_valid), 1);
        check("single_frame", 32'(bus.frame), 32'h3A);
        check("single_ack_pulse", 32'(bus.ack), 0);
        repeat (3) tick();
        check("single_fv_wait", 32'(bus.frame_valid), 1);
        force_busy = 1'b1;
        tick();
        check("single_fv_drop", 32'(bus.frame_valid), 0);
        tick();
        force_busy = 1'b0;
        tick();
        tick();

        // Valid held long after ack
        n0 = n_acks;
        f0 = n_frames;
        peak = 0;
        raise(4'h5, 4'hC);
        wait_ack();
        repeat (10) tick();
        check("long_valid_acks", 32'(n_acks - n0), 1);
        bus.valid = 1'b0;
        tick();
        auto_tx = 1'b1;
        drain();
        check("long_valid_frames", 32'(n_frames - f0), 1);
        check("long_valid_peak", 32'(peak), 1);

        // Fill with the transmitter busy; the extra word must wait for a slot
        force_busy = 1'b1;
        for (int i = 1; i <= CAP; i++) send_word(4'(i), 4'(i + 8), 0);
        check("fill_full", 32'(bus.full), 1);
        check("fill_count", 32'(bus.count), CAP);
        n0 = n_acks;
        raise(4'(CAP + 1), 4'(CAP + 9));
        repeat (5) tick();
        check("fill_no_ack", 32'(n_acks - n0), 0);
        force_busy = 1'b0;
        auto_tx = 1'b1;
        wait_ack();
        bus.valid = 1'b0;
        tick();
        drain();

`ifdef FRAME_ENC_FIFO_EN
        // Push and pop on the same edge
        force_busy = 1'b1;
        send_word(4'h1, 4'h1, 0);
        send_word(4'h2, 4'h2, 0);
        raise(4'h3, 4'h3);
        force_busy = 1'b0;
        tick();
        check("pp_ack", 32'(bus.ack), 1);
        check("pp_count", 32'(bus.count), 2);
        check("pp_frame", 32'(bus.frame), 32'h11);
        bus.valid = 1'b0;
        tick();
        auto_tx = 1'b1;
        drain();
`endif

        // Reset while a frame is offered and words remain buffered
        force_busy = 1'b1;
        for (int i = 0; i < CAP; i++) send_word(4'h6, 4'(i), 0);
        force_busy = 1'b0;
        tick();
        check("rst_mid_fv", 32'(bus.frame_valid), 1);
        check("rst_mid_count", 32'(bus.count), CAP - 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_fv", 32'(bus.frame_valid), 0);
        check("rst_async_count", 32'(bus.count), 0);
        check("rst_async_frame", 32'(bus.frame), 0);
        check("rst_async_full", 32'(bus.full), 0);
        exp_q.delete();
        fv_q      = 1'b0;
        low_cnt   = 100;
        acked     = 1'b1;
        bus.valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        auto_tx = 1'b1;
        send_word(4'hE, 4'h7, 1);
        drain();

        // Random traffic with a randomly slow transmitter
        auto_tx = 1'b1;
        for (int k = 0; k < 40; k++) begin
            send_word(4'($urandom), 4'($urandom), $urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
